// File: rtl/nco_cfg_pkg.sv
// Shared constants and types for the NCO configuration scheduler.
package nco_cfg_pkg;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_WAVE_LSB = 1;
  localparam int CTRL_DUTY     = 3;
  localparam int CTRL_FREQ     = 4;
  localparam int CTRL_SYNC     = 5;

  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam int WAVE_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    COMMIT    = 2'd2
  } state_e;

  typedef struct packed {
    logic              enable;
    logic [WAVE_W-1:0] wave;
    logic [FREQ_W-1:0] freq;
    logic [DUTY_W-1:0] duty;
  } nco_cfg_t;

endpackage

// File: rtl/nco_cfg_scheduler_if.sv
// Configuration transaction bus from the I2C register decoder.
interface nco_cfg_scheduler_if;
  import nco_cfg_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [7:0]        cfg_ctrl;
  logic [FREQ_W-1:0] cfg_freq;
  logic [DUTY_W-1:0] cfg_duty;

  modport master (output cfg_valid, output cfg_ctrl, output cfg_freq, output cfg_duty,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ctrl, input cfg_freq, input cfg_duty,
                  output cfg_ready);
endinterface

// File: rtl/nco_cfg_scheduler_watchdog.sv
// Saturating up-counter that bounds the time spent waiting for a phase wrap.
module nco_wrap_watchdog #(
  parameter int WRAP_TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic tc
);

  localparam int CNT_W = $clog2(WRAP_TIMEOUT);
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(WRAP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  // Count while enabled, holding at the top value instead of rolling over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/nco_cfg_scheduler.sv
// Captures one configuration transaction into shadow registers and commits it
// atomically to the NCO, either at once or on the next phase wrap.
//
// state     | meaning
// IDLE      | ready for a transaction, active regs stable
// WAIT_WRAP | shadow loaded, waiting for phase_wrap or watchdog expiry
// COMMIT    | shadow copied to active regs on the closing edge
module nco_cfg_scheduler
  import nco_cfg_pkg::*;
#(
  parameter int                WRAP_TIMEOUT = 1000000,
  parameter logic [DUTY_W-1:0] DUTY_RST     = 16'h8000
) (
  input  logic              clk,
  input  logic              reset,
  nco_cfg_scheduler_if.slave cfg,
  input  logic              phase_wrap,
  output logic              nco_enable,
  output logic [WAVE_W-1:0] nco_wave,
  output logic [FREQ_W-1:0] nco_frequency,
  output logic [DUTY_W-1:0] nco_duty_cycle,
  output logic              pending,
  output logic              commit_pulse,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_WAIT_WRAP = 2'(WAIT_WRAP);
  localparam logic [1:0] ST_COMMIT    = 2'(COMMIT);

  localparam nco_cfg_t RST_CFG = '{enable: 1'b0, wave: '0, freq: '0, duty: DUTY_RST};

  logic [1:0] state_q;
  nco_cfg_t   shadow_q;
  nco_cfg_t   active_q;
  logic       accept;
  logic       wd_tc;
  logic       unused_ctrl_bits;

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign accept        = cfg.cfg_valid && (state_q == ST_IDLE);
  assign pending       = (state_q != ST_IDLE);

  // Reserved control bits are accepted but carry no meaning.
  assign unused_ctrl_bits = ^cfg.cfg_ctrl[7:6];

  nco_wrap_watchdog #(
    .WRAP_TIMEOUT(WRAP_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != ST_WAIT_WRAP),
    .count_en (state_q == ST_WAIT_WRAP),
    .tc       (wd_tc)
  );

  // Sequencing FSM plus sticky watchdog flag and commit strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      commit_pulse <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            timeout_err <= 1'b0;
            // A disabled NCO never wraps, so waiting would only hit the watchdog.
            if (cfg.cfg_ctrl[CTRL_SYNC] && active_q.enable) begin
              state_q <= ST_WAIT_WRAP;
            end else begin
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_WAIT_WRAP: begin
          if (phase_wrap) begin
            state_q <= ST_COMMIT;
          end else if (wd_tc) begin
            state_q     <= ST_COMMIT;
            timeout_err <= 1'b1;
          end
        end
        ST_COMMIT: begin
          commit_pulse <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Shadow capture on accept; absent fields inherit the current active value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= RST_CFG;
    end else if (accept) begin
      shadow_q.enable <= cfg.cfg_ctrl[CTRL_EN];
      shadow_q.wave   <= cfg.cfg_ctrl[CTRL_WAVE_LSB +: WAVE_W];
      shadow_q.freq   <= cfg.cfg_ctrl[CTRL_FREQ] ? cfg.cfg_freq : active_q.freq;
      shadow_q.duty   <= cfg.cfg_ctrl[CTRL_DUTY] ? cfg.cfg_duty : active_q.duty;
    end
  end

  // Active registers change only as a whole, on the edge that leaves COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= RST_CFG;
    end else if (state_q == ST_COMMIT) begin
      active_q <= shadow_q;
    end
  end

  assign nco_enable     = active_q.enable;
  assign nco_wave       = active_q.wave;
  assign nco_frequency  = active_q.freq;
  assign nco_duty_cycle = active_q.duty;

endmodule

// File: doc/nco_cfg_scheduler.md
Name: nco_cfg_scheduler

Overview:
Sits between the I2C slave's decoded register writes and the NCO datapath. It captures one complete configuration transaction (control byte plus optional 64-bit frequency and 16-bit duty) into shadow registers. It then commits the transaction atomically to the NCO's active registers, either immediately or on the next NCO phase wrap, so the output never glitches mid-cycle. A watchdog forces the commit if no wrap arrives.

Parameters:
WRAP_TIMEOUT, 1000000, max clk cycles spent waiting for phase_wrap before a forced commit (>=2)
DUTY_RST, 16'h8000, active duty-cycle value after reset (50%)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  transaction from I2C slave ready (asserted after stop condition)
cfg_ready  out  1  scheduler can accept a transaction
cfg_ctrl  in  8  control byte: [0] enable, [2:1] wave, [3] duty present, [4] freq present, [5] commit-at-wrap, [7:6] reserved/ignored
cfg_freq  in  64  frequency tuning word, 32.32 fixed point; used only if cfg_ctrl[4]
cfg_duty  in  16  duty cycle; used only if cfg_ctrl[3]
phase_wrap  in  1  one-cycle pulse from NCO on accumulator wrap
nco_enable  out  1  active enable
nco_wave  out  2  active waveform select
nco_frequency  out  64  active tuning word
nco_duty_cycle  out  16  active duty cycle
pending  out  1  shadow holds an uncommitted transaction
commit_pulse  out  1  one-cycle pulse on the cycle after active registers update
timeout_err  out  1  sticky: last commit was forced by the watchdog

Behaviour:
- Reset (reset=0, async): state IDLE; nco_enable=0, nco_wave=0, nco_frequency=0, nco_duty_cycle=DUTY_RST; shadow regs equal to active; pending=0, commit_pulse=0, timeout_err=0; watchdog=0. Any in-flight transaction is discarded.
- cfg_ready = (state==IDLE). Handshake occurs on a clk edge with cfg_valid&cfg_ready. cfg_valid while not ready is held off; the source must hold valid and data stable.
- On accept:
  - shadow.enable=ctrl[0]; shadow.wave=ctrl[2:1].
  - shadow.freq=cfg_freq if ctrl[4], else the current nco_frequency.
  - shadow.duty=cfg_duty if ctrl[3], else the current nco_duty_cycle.
  - timeout_err cleared.
- FSM states IDLE, WAIT_WRAP, COMMIT:
  - IDLE -> COMMIT on accept when ctrl[5]=0, or when the current nco_enable=0 (a disabled NCO never wraps).
  - IDLE -> WAIT_WRAP on accept when ctrl[5]=1 and nco_enable=1; the watchdog is cleared.
  - WAIT_WRAP: watchdog increments each cycle.
    - phase_wrap=1 -> COMMIT.
    - Otherwise, watchdog==WRAP_TIMEOUT-1 -> COMMIT and timeout_err set.
    - If phase_wrap and the timeout fire in the same cycle, the wrap wins and timeout_err stays 0.
  - A phase_wrap in the accept cycle itself is ignored; only wraps strictly after acceptance count.
  - COMMIT: all four active outputs load from shadow in the same edge; commit_pulse=1 during the following cycle; -> IDLE.
- pending=1 in WAIT_WRAP and COMMIT.
- Latency: in immediate mode, accept at edge N, outputs change at edge N+1, commit_pulse high for the cycle after N+1, cfg_ready high again after N+1.
- phase_wrap in IDLE is ignored.
- Width rules: no arithmetic on data; the 64-bit and 16-bit fields pass through unmodified. The watchdog is $clog2(WRAP_TIMEOUT) bits and saturates; it never wraps.

Decomposition:
- Package nco_cfg_pkg:
  - CTRL_EN=0, CTRL_WAVE_LSB=1, CTRL_DUTY=3, CTRL_FREQ=4, CTRL_SYNC=5
  - state enum {IDLE, WAIT_WRAP, COMMIT}
  - field widths FREQ_W=64, DUTY_W=16, WAVE_W=2
- One sub-module: nco_wrap_watchdog (clear, count enable, terminal-count flag, parameter WRAP_TIMEOUT).

Test Plan:
- Reset defaults: release reset, then check nco_enable=0, nco_wave=0, nco_frequency=0, nco_duty_cycle=16'h8000, cfg_ready=1, pending=0.
- Immediate enable-only: ctrl=8'h05 -> one cycle later nco_enable=1 and nco_wave=2'b10. Frequency and duty are unchanged. One commit_pulse.
- Immediate frequency: ctrl=8'h15 with freq=64'h0001D4C0_00000000 -> nco_frequency[63:32]=32'h0001D4C0 one cycle after accept. Duty stays 16'h8000.
- Wrap-synchronised duty: with the NCO enabled, send ctrl=8'h2D with duty=16'h4000. pending=1 and outputs unchanged until phase_wrap is pulsed 50 cycles later. Duty becomes 16'h4000 at the edge after the wrap; cfg_valid asserted during the wait is not accepted (cfg_ready=0).
- Watchdog: WRAP_TIMEOUT=16, send ctrl=8'h35 with no phase_wrap -> forced commit after 16 cycles, timeout_err=1. Then a wrap coincident with the terminal count on the next transaction -> timeout_err=0.
- Reset mid-wait: assert reset while in WAIT_WRAP -> all outputs return to reset values immediately (asynchronously), pending=0, and the shadow transaction is never committed after release.
